// File: rtl/ps2_drive_ctrl.sv
// ps2_drive_ctrl
//   Turns a stream of PS/2 set-2 scan-code bytes into drive commands.
//   Arrow keys (E0-prefixed) and keypad 8/2/4/6 map to the same keys.
//   A prefix parser tracks E0/F0 bytes and keeps a held-key bitmap.
//   The direction outputs are decoded from that bitmap. A tick-driven
//   ramp raises or lowers the speed magnitude.
//
// Ports
//   CLOCK_50   in   1  system clock, rising edge
//   reset      in   1  synchronous active-low reset
//   rx_data    in   8  received byte, qualified by rx_valid
//   rx_valid   in   1  single-cycle byte strobe
//   accel      out  2  01 forward, 10 reverse, 00 coast
//   turn       out  2  01 left, 10 right, 00 straight
//   speed      out  4  ramped speed magnitude 0..MAX_SPEED
//   held       out  4  held keys {right,left,down,up}
//   last_code  out  8  last non-prefix byte accepted
module ps2_drive_ctrl #(
  parameter int RAMP_DIV       = 2500000,
  parameter int MAX_SPEED      = 15,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] accel,
  output logic [1:0] turn,
  output logic [3:0] speed,
  output logic [3:0] held,
  output logic [7:0] last_code
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [4:0]    SPD_MAX   = 5'(MAX_SPEED);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t        state_r, state_next_s;
  logic [TW-1:0] tmo_r, tmo_next_s;
  logic [RW-1:0] ramp_r;
  logic [3:0]    held_r, held_next_s;
  logic [7:0]    last_code_r;
  logic [1:0]    accel_r, turn_r, last_dir_r;
  logic [3:0]    speed_r;
  logic          code_valid_s, is_break_s, tick_s, reversal_s;
  logic [4:0]    speed_next_s;

  // Bitmap bit for a recognised key code; zero for anything else.
  function automatic logic [3:0] key_mask(input logic [7:0] code);
    case (code)
      8'h75:   key_mask = 4'b0001;
      8'h72:   key_mask = 4'b0010;
      8'h6B:   key_mask = 4'b0100;
      8'h74:   key_mask = 4'b1000;
      default: key_mask = 4'b0000;
    endcase
  endfunction

  // Opposing-pair decode: one side only gives a direction, both or none coast.
  function automatic logic [1:0] pair_dir(input logic a, input logic b);
    if (a && !b) begin
      pair_dir = 2'b01;
    end else if (b && !a) begin
      pair_dir = 2'b10;
    end else begin
      pair_dir = 2'b00;
    end
  endfunction

  // Prefix parser next state, byte classification and idle timeout.
  always_comb begin
    state_next_s = state_r;
    tmo_next_s   = {TW{1'b0}};
    code_valid_s = 1'b0;
    is_break_s   = 1'b0;
    if (rx_valid) begin
      if (rx_data == 8'hE1) begin
        state_next_s = IDLE;
      end else if (rx_data == 8'hE0) begin
        case (state_r)
          IDLE:     state_next_s = GOT_E0;
          GOT_E0:   state_next_s = GOT_E0;
          GOT_F0:   state_next_s = GOT_E0F0;
          GOT_E0F0: state_next_s = GOT_E0F0;
          default:  state_next_s = IDLE;
        endcase
      end else if (rx_data == 8'hF0) begin
        case (state_r)
          IDLE:     state_next_s = GOT_F0;
          GOT_E0:   state_next_s = GOT_E0F0;
          GOT_F0:   state_next_s = GOT_F0;
          GOT_E0F0: state_next_s = GOT_E0F0;
          default:  state_next_s = IDLE;
        endcase
      end else begin
        code_valid_s = 1'b1;
        is_break_s   = (state_r == GOT_F0) || (state_r == GOT_E0F0);
        state_next_s = IDLE;
      end
    end else if (state_r != IDLE) begin
      // A stalled prefix is dropped so the next code is read as a make.
      if (tmo_r == TMO_LAST) begin
        state_next_s = IDLE;
      end else begin
        tmo_next_s = tmo_r + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      tmo_next_s = {TW{1'b0}};
    end
  end

  // Held bitmap update; repeat makes and unknown codes leave it unchanged.
  always_comb begin
    held_next_s = held_r;
    if (code_valid_s) begin
      if (is_break_s) begin
        held_next_s = held_r & ~key_mask(rx_data);
      end else begin
        held_next_s = held_r | key_mask(rx_data);
      end
    end else begin
      held_next_s = held_r;
    end
  end

  // Speed ramp; a flip of motion direction (even via coast) zeroes speed.
  always_comb begin
    tick_s       = (ramp_r == RAMP_LAST);
    reversal_s   = (accel_r != 2'b00) && (last_dir_r != 2'b00) &&
                   (accel_r != last_dir_r);
    speed_next_s = {1'b0, speed_r};
    if (reversal_s) begin
      speed_next_s = 5'd0;
    end else if (tick_s) begin
      if (accel_r != 2'b00) begin
        if ({1'b0, speed_r} < SPD_MAX) begin
          speed_next_s = {1'b0, speed_r} + 5'd1;
        end else begin
          speed_next_s = SPD_MAX;
        end
      end else begin
        if (speed_r != 4'd0) begin
          speed_next_s = {1'b0, speed_r} - 5'd1;
        end else begin
          speed_next_s = 5'd0;
        end
      end
    end else begin
      speed_next_s = {1'b0, speed_r};
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_r     <= IDLE;
      tmo_r       <= {TW{1'b0}};
      ramp_r      <= {RW{1'b0}};
      held_r      <= 4'd0;
      last_code_r <= 8'h00;
      accel_r     <= 2'b00;
      turn_r      <= 2'b00;
      last_dir_r  <= 2'b00;
      speed_r     <= 4'd0;
    end else begin
      state_r     <= state_next_s;
      tmo_r       <= tmo_next_s;
      ramp_r      <= tick_s ? {RW{1'b0}} : ramp_r + {{(RW-1){1'b0}}, 1'b1};
      held_r      <= held_next_s;
      last_code_r <= code_valid_s ? rx_data : last_code_r;
      accel_r     <= pair_dir(held_r[0], held_r[1]);
      turn_r      <= pair_dir(held_r[2], held_r[3]);
      last_dir_r  <= (accel_r != 2'b00) ? accel_r : last_dir_r;
      speed_r     <= speed_next_s[3:0];
    end
  end

  assign accel     = accel_r;
  assign turn      = turn_r;
  assign speed     = speed_r;
  assign held      = held_r;
  assign last_code = last_code_r;

endmodule

// File: tb/tb_ps2_drive_ctrl.sv
// Bench for ps2_drive_ctrl: byte table, scenario sequences and random
// traffic, all compared every cycle with a behavioural key/speed model.
module tb_ps2_drive_ctrl;

  localparam int RAMP_DIV = 20;
  localparam int MAX_SPD  = 15;
  localparam int TMO      = 30;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] accel, turn;
  logic [3:0] speed, held;
  logic [7:0] last_code;

  int n_total = 0;
  int n_pass  = 0;

  ps2_drive_ctrl #(.RAMP_DIV(RAMP_DIV), .MAX_SPEED(MAX_SPD), .PREFIX_TIMEOUT(TMO)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .accel(accel), .turn(turn), .speed(speed), .held(held), .last_code(last_code)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // ---------------- behavioural model ----------------
  bit         m_pending, m_break;   // prefix seen / break seen in this sequence
  int         m_idle;               // idle cycles spent with a pending prefix
  bit         m_key [4];            // up, down, left, right
  int         m_accel, m_turn;      // 0 none, 1 first, 2 second direction
  int         m_speed, m_ramp, m_last_motion;
  logic [7:0] m_last;

  function automatic int dir_of(bit a, bit b);
    return (a && !b) ? 1 : ((b && !a) ? 2 : 0);
  endfunction

  function automatic int key_idx(logic [7:0] c);
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic mstep(input logic r, input logic v, input logic [7:0] d);
    int k;
    bit tick;
    if (!r) begin
      m_pending = 0; m_break = 0; m_idle = 0;
      foreach (m_key[i]) m_key[i] = 0;
      m_accel = 0; m_turn = 0; m_speed = 0; m_ramp = 0; m_last_motion = 0;
      m_last = 8'h00;
      return;
    end
    // speed reacts to the direction already shown on accel
    tick   = (m_ramp == RAMP_DIV - 1);
    m_ramp = tick ? 0 : m_ramp + 1;
    if (m_accel != 0 && m_last_motion != 0 && m_accel != m_last_motion) m_speed = 0;
    else if (tick && m_accel != 0) m_speed = (m_speed < MAX_SPD) ? m_speed + 1 : MAX_SPD;
    else if (tick) m_speed = (m_speed > 0) ? m_speed - 1 : 0;
    if (m_accel != 0) m_last_motion = m_accel;
    // directions follow the keys one cycle late
    m_accel = dir_of(m_key[0], m_key[1]);
    m_turn  = dir_of(m_key[2], m_key[3]);
    // byte parsing
    if (v) begin
      m_idle = 0;
      if (d == 8'hE1) begin
        m_pending = 0; m_break = 0;
      end else if (d == 8'hE0) begin
        m_pending = 1;
      end else if (d == 8'hF0) begin
        m_pending = 1; m_break = 1;
      end else begin
        k = key_idx(d);
        if (k >= 0) m_key[k] = !m_break;
        m_last = d; m_pending = 0; m_break = 0;
      end
    end else if (m_pending) begin
      m_idle++;
      if (m_idle == TMO) begin m_pending = 0; m_break = 0; m_idle = 0; end
    end else begin
      m_idle = 0;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    logic [3:0] mh;
    reset = r; rx_valid = v; rx_data = d;
    @(posedge CLOCK_50);
    mstep(r, v, d);
    #1;
    mh = {m_key[3], m_key[2], m_key[1], m_key[0]};
    chk("model", {6'd0, held, accel, turn, speed, last_code},
        {6'd0, mh, 2'(m_accel), 2'(m_turn), 4'(m_speed), m_last});
    @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, 1'b1, b);
    cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  // which: 0 waits on speed, 1 waits on accel
  task automatic wait_for(input int which, input int target, input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle(1'b1, 1'b0, 8'h00);
      if (which == 0 && int'(speed) == target) done = 1;
      if (which == 1 && int'(accel) == target) done = 1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_held;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [$];
  logic [7:0] pool [10];

  initial begin
    vecs = '{
      '{8'h75, 4'b0001, 8'h75}, '{8'h75, 4'b0001, 8'h75},
      '{8'hE0, 4'b0001, 8'h75}, '{8'h72, 4'b0011, 8'h72},
      '{8'hF0, 4'b0011, 8'h72}, '{8'h75, 4'b0010, 8'h75},
      '{8'hE1, 4'b0010, 8'h75}, '{8'h14, 4'b0010, 8'h14},
      '{8'h77, 4'b0010, 8'h77}, '{8'hE0, 4'b0010, 8'h77},
      '{8'hF0, 4'b0010, 8'h77}, '{8'h72, 4'b0000, 8'h72},
      '{8'h6B, 4'b0100, 8'h6B}, '{8'hE0, 4'b0100, 8'h6B},
      '{8'h74, 4'b1100, 8'h74}, '{8'hF0, 4'b1100, 8'h74},
      '{8'hE0, 4'b1100, 8'h74}, '{8'h6B, 4'b1000, 8'h6B},
      '{8'hF0, 4'b1000, 8'h6B}, '{8'hF0, 4'b1000, 8'h6B},
      '{8'h74, 4'b0000, 8'h74}, '{8'hE0, 4'b0000, 8'h74},
      '{8'hE1, 4'b0000, 8'h74}, '{8'h75, 4'b0001, 8'h75}
    };
    pool = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h14, 8'h77};

    @(negedge CLOCK_50);
    do_reset();
    chk("reset_held", {28'd0, held}, 32'd0);
    chk("reset_speed", {28'd0, speed}, 32'd0);
    chk("reset_last", {24'd0, last_code}, 32'd0);

    // byte table
    foreach (vecs[i]) begin
      send(vecs[i].data);
      chk($sformatf("tbl_held%0d", i), {28'd0, held}, {28'd0, vecs[i].exp_held});
      chk($sformatf("tbl_last%0d", i), {24'd0, last_code}, {24'd0, vecs[i].exp_last});
    end

    // press/release with decay
    do_reset();
    send(8'hE0); send(8'h75);
    wait_for(0, 3, 4 * RAMP_DIV + 10, "ramp_to_3");
    chk("seq32_held", {28'd0, held}, 32'h1);
    chk("seq32_accel", {30'd0, accel}, 32'h1);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(3 * RAMP_DIV + 5);
    chk("seq32_decay", {28'd0, speed}, 32'd0);
    chk("seq32_coast", {30'd0, accel}, 32'd0);

    // saturation
    send(8'h75);
    idle(20 * RAMP_DIV + 5);
    chk("sat_speed", {28'd0, speed}, 32'd15);

    // both pedals then reversal through coast
    do_reset();
    send(8'h75);
    wait_for(0, 5, 6 * RAMP_DIV + 10, "ramp_to_5");
    send(8'h72); idle(2);
    chk("both_accel", {30'd0, accel}, 32'd0);
    wait_for(0, 4, RAMP_DIV + 5, "both_decay");
    send(8'hF0); send(8'h75);
    wait_for(1, 2, 5, "rev_accel");
    idle(1);
    chk("rev_zero", {28'd0, speed}, 32'd0);
    wait_for(0, 2, 3 * RAMP_DIV + 5, "rev_ramp");

    // steering
    do_reset();
    send(8'h6B); send(8'h74); idle(1);
    chk("turn_both", {30'd0, turn}, 32'd0);
    chk("turn_held", {28'd0, held}, 32'hC);
    send(8'hF0); send(8'h6B); idle(1);
    chk("turn_right", {30'd0, turn}, 32'h2);

    // prefix timeout and reset mid-sequence
    do_reset();
    send(8'hF0); idle(TMO);
    send(8'h75);
    chk("tmo_make", {28'd0, held}, 32'h1);
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h75);
    chk("rst_make", {28'd0, held}, 32'h1);
    send(8'hE0); idle(TMO - 3);
    send(8'hF0); send(8'h75);
    chk("no_tmo_break", {28'd0, held}, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) cycle(1'b0, $urandom_range(0, 1), 8'h75);
      else if ($urandom_range(0, 3) == 0)
        cycle(1'b1, 1'b1, ($urandom_range(0, 9) == 9) ? 8'($urandom) : pool[$urandom_range(0, 9)]);
      else if ($urandom_range(0, 30) == 0) idle($urandom_range(TMO - 2, TMO + 2));
      else cycle(1'b1, 1'b0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
